if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 32, PC / fetch address width (word-addressed; sequential PC increments by 1).
REQ-002 Parameter DATA_W, default 32, instruction width; opcode is inst[4:0].
REQ-003 Parameter DEPTH, default 4, instruction queue entries; power of two, >=2.
REQ-004 Parameter RESET_PC, default 0, PC after reset.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 redirect_valid  in  1  jump/branch-taken redirect from execute.
REQ-008 redirect_pc  in  ADDR_W  redirect target.
REQ-009 resolve_nt  in  1  pending control instruction resolved not-taken.
REQ-010 stall  in  1  pipeline hold; blocks new memory requests only.
REQ-011 imem_req_valid  out  1  fetch request valid.
REQ-012 imem_req_addr  out  ADDR_W  fetch address (= fetch PC).
REQ-013 imem_req_ready  in  1  memory accepts request.
REQ-014 imem_rsp_valid  in  1  in-order response valid, >=1 cycle after acceptance.
REQ-015 imem_rsp_data  in  DATA_W  response instruction.
REQ-016 out_valid  out  1  queue head valid to decode.
REQ-017 out_inst  out  DATA_W  head instruction.
REQ-018 out_pc  out  ADDR_W  head instruction address.
REQ-019 out_ready  in  1  decode consumes head when out_valid&out_ready.

Function
REQ-020 Request fires on imem_req_valid&imem_req_ready; fetch PC then increments by 1 (wraps mod 2^ADDR_W).
REQ-021 imem_req_valid = state FETCH & ~stall & ~redirect_valid & (queue_count + outstanding < DEPTH).
REQ-022 Outstanding counter +1 on fire, -1 on response; never exceeds DEPTH; response without outstanding is ignored.
REQ-023 Each accepted response enqueues {data, pc}; pc tagged from an internal FIFO of issued addresses; queue never overflows by credit rule (REQ-021).
REQ-024 Simultaneous enqueue and dequeue in same cycle: both occur, count unchanged; full queue with dequeue accepts response.
REQ-025 States: FETCH, BR_WAIT. FETCH->BR_WAIT when an enqueued instruction has opcode `BEQ, `BLE, `JAL or `JR; requests after it already issued are dropped (treated as flushed).
REQ-026 BR_WAIT: no requests; BR_WAIT->FETCH on resolve_nt (PC = control instr pc+1) or redirect_valid.
REQ-027 redirect_valid (any state): next cycle queue empty, out_valid=0, fetch PC=redirect_pc, state FETCH; all outstanding responses discarded via drop counter = outstanding at redirect.
REQ-028 redirect_valid and resolve_nt same cycle: redirect wins.
REQ-029 Redirect during fire cycle: that request is not issued (REQ-021); a response arriving in redirect cycle is discarded.
REQ-030 stall does not affect dequeue or response capture.
REQ-031 out_valid = queue non-empty; out_inst/out_pc from head; stable while out_valid&~out_ready.

Reset
REQ-032 During/after reset: fetch PC=RESET_PC, state FETCH, queue empty, outstanding=0, drop counter=0, out_valid=0, out_inst=0, out_pc=0, imem_req_valid=0 while rst_n low.
REQ-033 Reset mid-operation abandons all outstanding requests; responses after release with zero outstanding are ignored.

Configuration
REQ-034 Macro IFQ_BYPASS_EN defined: queue empty & imem_rsp_valid (not dropped) & out_ready -> response presented same cycle on out_* and not enqueued.
REQ-035 IFQ_BYPASS_EN undefined: responses always enqueued; out_valid earliest one cycle after response.

Verification
REQ-036 Reset release, ready=1, 1-cycle memory returning non-control insts, out_ready=1 -> addresses 0,1,2,3...; out_pc 0,1,2 in order.
REQ-037 out_ready=0, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0; out_ready=1 resumes fetch at address 4.
REQ-038 Inst at pc 5 opcode `BEQ -> state BR_WAIT, pc 6+ responses dropped; resolve_nt -> next request address 6.
REQ-039 redirect_valid, redirect_pc=0x40 with 2 outstanding -> both responses discarded, out_valid=0 next cycle, next request 0x40.
REQ-040 stall=1 for 3 cycles -> no requests, queued insts still drain; release resumes at held PC.
REQ-041 IFQ_BYPASS_EN defined, empty queue, response 0x1234 at pc 0 with out_ready=1 -> out_valid=1, out_inst=0x1234 same cycle; undefined -> next cycle.

Source files
------------

// File: rtl/if_fetch_queue.sv
`timescale 1ns/1ps
// if_fetch_queue
// Instruction fetch front end. It issues sequential fetch requests under a
// credit limit (queued + outstanding <= DEPTH), tags in-order responses with
// their PCs from an issued-address FIFO, and buffers them for decode. An
// enqueued control instruction parks the unit in BR_WAIT until it is resolved
// not-taken or a redirect arrives. Responses that belong to abandoned
// requests are discarded through a drop counter.
// Build option: define IFQ_BYPASS_EN to forward a response straight to the
// decode port when the queue is empty and decode is ready.

`ifndef BEQ
`define BEQ 5'h18
`endif
`ifndef BLE
`define BLE 5'h19
`endif
`ifndef JAL
`define JAL 5'h1a
`endif
`ifndef JR
`define JR  5'h1b
`endif

module if_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              resolve_nt,
    input  logic              stall,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // Dropped responses can pile up across back-to-back flushes, so the
    // drop counter gets extra headroom over the live outstanding count.
    localparam int DROP_W = PTR_W + 3;

    typedef enum logic [0:0] {
        S_FETCH   = 1'b0,
        S_BR_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                run_q, run_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   ctrl_pc_q, ctrl_pc_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic [DATA_W-1:0]   q_data_q [DEPTH];
    logic [DATA_W-1:0]   q_data_d [DEPTH];
    logic [ADDR_W-1:0]   q_pc_q   [DEPTH];
    logic [ADDR_W-1:0]   q_pc_d   [DEPTH];
    logic [PTR_W-1:0]    q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [CNT_W-1:0]    q_cnt_q, q_cnt_d;

    logic [ADDR_W-1:0]   a_mem_q  [DEPTH];
    logic [ADDR_W-1:0]   a_mem_d  [DEPTH];
    logic [PTR_W-1:0]    a_rd_q, a_rd_d, a_wr_q, a_wr_d;

    logic                fire;
    logic                rsp_any;
    logic                rsp_drop;
    logic                rsp_live;
    logic                rsp_ctrl;
    logic                bypass;
    logic                enq;
    logic                deq;
    logic                credit_ok;
    logic [4:0]          rsp_op;

    assign rsp_op    = imem_rsp_data[4:0];
    assign credit_ok = (({1'b0, q_cnt_q} + {1'b0, out_cnt_q}) < (CNT_W + 1)'(DEPTH));

    assign imem_req_valid = run_q & (state_q == S_FETCH) & ~stall & ~redirect_valid & credit_ok;
    assign imem_req_addr  = pc_q;
    assign fire           = imem_req_valid & imem_req_ready;

    // Responses are consumed by pending drops first; a response with nothing
    // in flight at all is simply ignored.
    assign rsp_any  = imem_rsp_valid & ((drop_q != '0) | (out_cnt_q != '0));
    assign rsp_drop = imem_rsp_valid & (drop_q != '0);
    assign rsp_live = imem_rsp_valid & (drop_q == '0) & (out_cnt_q != '0) & ~redirect_valid;
    assign rsp_ctrl = rsp_live & (state_q == S_FETCH) &
                      ((rsp_op == `BEQ) | (rsp_op == `BLE) | (rsp_op == `JAL) | (rsp_op == `JR));

`ifdef IFQ_BYPASS_EN
    assign bypass = rsp_live & (q_cnt_q == '0) & out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign enq = rsp_live & ~bypass;
    assign deq = (q_cnt_q != '0) & out_ready;

    assign out_valid = (q_cnt_q != '0) | bypass;
    assign out_inst  = bypass ? imem_rsp_data    : q_data_q[q_rd_q];
    assign out_pc    = bypass ? a_mem_q[a_rd_q]  : q_pc_q[q_rd_q];

    // Next-state: request issue, response tagging, queue, FSM and flushes.
    always_comb begin
        state_d   = state_q;
        run_d     = 1'b1;
        pc_d      = pc_q;
        ctrl_pc_d = ctrl_pc_q;
        drop_d    = drop_q;
        q_data_d  = q_data_q;
        q_pc_d    = q_pc_q;
        q_rd_d    = q_rd_q;
        q_wr_d    = q_wr_q;
        a_mem_d   = a_mem_q;
        a_rd_d    = a_rd_q;
        a_wr_d    = a_wr_q;

        if (fire) begin
            pc_d            = pc_q + ADDR_W'(1);
            a_mem_d[a_wr_q] = pc_q;
            a_wr_d          = a_wr_q + PTR_W'(1);
        end
        if (rsp_live) begin
            a_rd_d = a_rd_q + PTR_W'(1);
        end
        out_cnt_d = out_cnt_q + CNT_W'(fire) - CNT_W'(rsp_live);
        if (rsp_drop) begin
            drop_d = drop_q - DROP_W'(1);
        end

        if (enq) begin
            q_data_d[q_wr_q] = imem_rsp_data;
            q_pc_d[q_wr_q]   = a_mem_q[a_rd_q];
            q_wr_d           = q_wr_q + PTR_W'(1);
        end
        if (deq) begin
            q_rd_d = q_rd_q + PTR_W'(1);
        end
        q_cnt_d = q_cnt_q + CNT_W'(enq) - CNT_W'(deq);

        case (state_q)
            S_FETCH: begin
                // Everything issued behind the control instruction, including
                // a request firing this very cycle, becomes a drop.
                if (rsp_ctrl) begin
                    state_d   = S_BR_WAIT;
                    ctrl_pc_d = a_mem_q[a_rd_q];
                    drop_d    = DROP_W'(out_cnt_q) + DROP_W'(fire) - DROP_W'(1);
                    out_cnt_d = '0;
                    a_rd_d    = '0;
                    a_wr_d    = '0;
                end
            end
            S_BR_WAIT: begin
                if (resolve_nt) begin
                    state_d = S_FETCH;
                    pc_d    = ctrl_pc_q + ADDR_W'(1);
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Redirect overrides everything, including a same-cycle resolve.
        if (redirect_valid) begin
            state_d   = S_FETCH;
            pc_d      = redirect_pc;
            drop_d    = drop_q + DROP_W'(out_cnt_q) - DROP_W'(rsp_any);
            out_cnt_d = '0;
            q_cnt_d   = '0;
            q_rd_d    = '0;
            q_wr_d    = '0;
            a_rd_d    = '0;
            a_wr_d    = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            run_q     <= 1'b0;
            pc_q      <= RESET_PC;
            ctrl_pc_q <= '0;
            out_cnt_q <= '0;
            drop_q    <= '0;
            q_rd_q    <= '0;
            q_wr_q    <= '0;
            q_cnt_q   <= '0;
            a_rd_q    <= '0;
            a_wr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data_q[i] <= '0;
                q_pc_q[i]   <= '0;
                a_mem_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            pc_q      <= pc_d;
            ctrl_pc_q <= ctrl_pc_d;
            out_cnt_q <= out_cnt_d;
            drop_q    <= drop_d;
            q_rd_q    <= q_rd_d;
            q_wr_q    <= q_wr_d;
            q_cnt_q   <= q_cnt_d;
            a_rd_q    <= a_rd_d;
            a_wr_q    <= a_wr_d;
            q_data_q  <= q_data_d;
            q_pc_q    <= q_pc_d;
            a_mem_q   <= a_mem_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
`timescale 1ns/1ps
// Testbench for if_fetch_queue: cycle table for fill/credit/stall behaviour,
// hand sequences for branch wait, redirect, reset abandonment and bypass
// timing, and a randomized run checked against a stream-level model.

`ifndef BEQ
`define BEQ 5'h18
`endif
`ifndef BLE
`define BLE 5'h19
`endif
`ifndef JAL
`define JAL 5'h1a
`endif
`ifndef JR
`define JR  5'h1b
`endif

module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        resolve_nt;
    logic        stall;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    always #5 clk = ~clk;

    if_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .resolve_nt(resolve_nt), .stall(stall),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_ready(out_ready)
    );

    int errors = 0;
    int checks = 0;

    // Memory image: one optional special word, otherwise a non-control opcode.
    logic        sp_en;
    logic [31:0] sp_pc;
    logic [31:0] sp_word;

    // Reference model state.
    logic [31:0] exp_req;
    logic [31:0] exp_next;
    logic [31:0] br_pc;
    bit          br_pending;
    bit          chk_empty;
    logic [31:0] mem_q[$];
    bit          mem_en;
    bit          mem_hold;
    int          mem_rate;

    // Samples taken at the falling edge of the last stepped cycle.
    logic        s_req_valid, s_out_valid, s_rsp_valid;
    logic [31:0] s_req_addr, s_out_pc, s_out_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (sp_en && a == sp_pc) return sp_word;
        return {a[26:0] ^ 27'h2a5a5a5, 5'h01};
    endfunction

    function automatic bit is_ctrl(input logic [4:0] op);
        return op == `BEQ || op == `BLE || op == `JAL || op == `JR;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit keep_mem);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        resolve_nt     = 1'b0;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        out_ready      = 1'b0;
        if (!keep_mem) mem_q.delete();
        exp_req    = 32'h0;
        exp_next   = 32'h0;
        br_pending = 1'b0;
        chk_empty  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_inst",  out_inst, 32'h0);
        chk("rst_out_pc",    out_pc, 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle: sample and check at negedge, then advance the
    // in-order memory after the rising edge.
    task automatic step();
        bit fire, cons, took;
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_inst  = out_inst;
        s_rsp_valid = imem_rsp_valid;
        fire = imem_req_valid & imem_req_ready;
        cons = out_valid & out_ready;
        took = imem_rsp_valid;
        if (chk_empty) begin
            chk("empty_after_redirect", 32'(out_valid), 32'h0);
            chk_empty = 1'b0;
        end
        if (stall || redirect_valid) chk("no_req_when_blocked", 32'(imem_req_valid), 32'h0);
        if (br_pending) chk("no_req_in_br_wait", 32'(imem_req_valid), 32'h0);
        if (fire && !br_pending) begin
            chk("req_addr", imem_req_addr, exp_req);
            exp_req = exp_req + 1;
        end
        if (cons) begin
            if (br_pending) chk("no_out_past_branch", 32'(out_pc > br_pc), 32'h0);
            chk("out_pc", out_pc, exp_next);
            chk("out_inst", out_inst, mem_word(exp_next));
            exp_next = exp_next + 1;
        end
        if (redirect_valid) begin
            exp_req    = redirect_pc;
            exp_next   = redirect_pc;
            chk_empty  = 1'b1;
            br_pending = 1'b0;
        end else begin
            if (resolve_nt && br_pending) begin
                exp_req    = br_pc + 1;
                br_pending = 1'b0;
            end
            if (imem_rsp_valid && is_ctrl(imem_rsp_data[4:0]) && mem_en && mem_q.size() > 0) begin
                br_pending = 1'b1;
                br_pc      = mem_q[0];
            end
        end
        @(posedge clk);
        #1;
        if (mem_en) begin
            if (took && mem_q.size() > 0) void'(mem_q.pop_front());
            if (fire) mem_q.push_back(s_req_addr);
            imem_rsp_valid = (mem_q.size() > 0) && !mem_hold && ($urandom_range(99) < mem_rate);
            imem_rsp_data  = (mem_q.size() > 0) ? mem_word(mem_q[0]) : 32'h0;
        end
    endtask

    typedef struct {
        bit          st;
        bit          rv;
        logic [31:0] rpc;
        bit          ordy;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_ov;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sp_en = 1'b0; sp_pc = '0; sp_word = '0;
        mem_en = 1'b0; mem_hold = 1'b0; mem_rate = 100; br_pc = '0;

        // Fill with decode blocked, resume, then a 3-cycle stall.
        //           st rv rpc ordy  e_rv e_addr e_ov e_pc
        tbl[0]  = '{0, 0, 0, 0,  1, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0,  1, 1, 0, 0};
        tbl[2]  = '{0, 1, 1, 0,  1, 2, 1, 0};
        tbl[3]  = '{0, 1, 2, 0,  1, 3, 1, 0};
        tbl[4]  = '{0, 1, 3, 0,  0, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 0,  0, 0, 1, 0};
        tbl[6]  = '{0, 0, 0, 1,  0, 0, 1, 0};
        tbl[7]  = '{0, 0, 0, 0,  1, 4, 1, 1};
        tbl[8]  = '{0, 1, 4, 1,  0, 0, 1, 1};
        tbl[9]  = '{0, 0, 0, 1,  1, 5, 1, 2};
        tbl[10] = '{1, 1, 5, 1,  0, 0, 1, 3};
        tbl[11] = '{1, 0, 0, 1,  0, 0, 1, 4};
        tbl[12] = '{1, 0, 0, 1,  0, 0, 1, 5};
        tbl[13] = '{0, 0, 0, 1,  1, 6, 0, 0};
        tbl[14] = '{0, 1, 6, 0,  1, 7, 0, 0};
        tbl[15] = '{0, 1, 7, 0,  1, 8, 1, 6};

        do_reset(0);
        for (int i = 0; i < 16; i++) begin
            stall          = tbl[i].st;
            imem_rsp_valid = tbl[i].rv;
            imem_rsp_data  = mem_word(tbl[i].rpc);
            out_ready      = tbl[i].ordy;
            step();
            chk($sformatf("tbl%0d_req_valid", i), 32'(s_req_valid), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv) chk($sformatf("tbl%0d_req_addr", i), s_req_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_out_valid", i), 32'(s_out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_out_pc", i), s_out_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_out_inst", i), s_out_inst, mem_word(tbl[i].e_pc));
            end
        end
        imem_rsp_valid = 1'b0;
        mem_en = 1'b1;

        // Control instruction at pc 5, resolved not-taken.
        do_reset(0);
        sp_en = 1'b1; sp_pc = 32'd5; sp_word = {27'h0000123, `BEQ};
        out_ready = 1'b1;
        begin
            int n = 0;
            while (!br_pending && n < 40) begin step(); n++; end
            chk("branch_seen", 32'(br_pending), 32'h1);
        end
        repeat (8) step();
        chk("drained_to_branch", exp_next, 32'd6);
        resolve_nt = 1'b1;
        step();
        resolve_nt = 1'b0;
        repeat (12) step();
        chk("resumed_after_resolve", 32'(exp_next >= 32'd8), 32'h1);

        // Redirect and resolve together while waiting: redirect wins.
        do_reset(0);
        out_ready = 1'b1;
        begin
            int n = 0;
            while (!br_pending && n < 40) begin step(); n++; end
            chk("branch_seen2", 32'(br_pending), 32'h1);
        end
        repeat (6) step();
        redirect_valid = 1'b1; redirect_pc = 32'h100; resolve_nt = 1'b1; out_ready = 1'b0;
        step();
        redirect_valid = 1'b0; resolve_nt = 1'b0; out_ready = 1'b1;
        repeat (12) step();
        chk("redirect_over_resolve", 32'(exp_next >= 32'h102), 32'h1);
        sp_en = 1'b0;

        // Redirect to 0x40 with two requests outstanding.
        do_reset(0);
        out_ready = 1'b1; mem_hold = 1'b1;
        repeat (2) step();
        chk("two_outstanding", 32'(mem_q.size()), 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b0;
        step();
        redirect_valid = 1'b0; out_ready = 1'b1; mem_hold = 1'b0;
        repeat (12) step();
        chk("redirect_progress", 32'(exp_next >= 32'h42), 32'h1);

        // Reset with requests in flight: late responses must be ignored.
        do_reset(0);
        out_ready = 1'b1; mem_hold = 1'b1;
        repeat (3) step();
        do_reset(1);
        stall = 1'b1; out_ready = 1'b1; mem_hold = 1'b0;
        repeat (6) begin
            step();
            chk("stale_rsp_ignored", 32'(s_out_valid), 32'h0);
        end
        stall = 1'b0;
        repeat (12) step();
        chk("restart_after_reset", 32'(exp_next >= 32'd2), 32'h1);

        // First response presented to decode: same cycle only with bypass.
        do_reset(0);
        sp_en = 1'b1; sp_pc = 32'h0; sp_word = 32'h1234;
        out_ready = 1'b1;
        begin
            int n = 0;
            step();
            while (!s_rsp_valid && n < 20) begin step(); n++; end
            chk("bypass_rsp_seen", 32'(s_rsp_valid), 32'h1);
        end
`ifdef IFQ_BYPASS_EN
        chk("bypass_same_valid", 32'(s_out_valid), 32'h1);
        chk("bypass_same_inst", s_out_inst, 32'h1234);
        chk("bypass_same_pc", s_out_pc, 32'h0);
`else
        chk("nobypass_same_valid", 32'(s_out_valid), 32'h0);
        step();
        chk("nobypass_next_valid", 32'(s_out_valid), 32'h1);
        chk("nobypass_next_inst", s_out_inst, 32'h1234);
        chk("nobypass_next_pc", s_out_pc, 32'h0);
`endif
        sp_en = 1'b0;

        // Randomized traffic with stalls, backpressure and redirects.
        do_reset(0);
        mem_rate = 70;
        for (int c = 0; c < 3000; c++) begin
            stall          = ($urandom_range(4) == 0);
            imem_req_ready = ($urandom_range(3) != 0);
            out_ready      = ($urandom_range(2) != 0);
            redirect_valid = ($urandom_range(59) == 0);
            redirect_pc    = $urandom;
            if (redirect_valid) out_ready = 1'b0;
            step();
        end
        redirect_valid = 1'b0;
        chk("random_progress", 32'(checks > 1000), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
